// File: rtl/jtbubl_linebuf_pkg.sv
// Shared constants and readout state encoding for the object line buffer.
package jtbubl_linebuf_pkg;

  // Palette index of an empty pixel; every location returns to it after scan-out
  localparam logic [7:0] BLANK = 8'hFF;

  // Colour nibble that marks a draw pixel as see-through (never written)
  localparam logic [3:0] TRANSP = 4'hF;

  // Readout pass: present the address, then capture the data and clear the location
  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

endpackage

// File: rtl/jtbubl_linebuf_if.sv
// Bundle of draw-side and video-side signals between the line buffer and its users.
interface jtbubl_linebuf_if #(
  parameter int AW = 8
);

  logic          pxl_cen;
  logic          LHBL;
  logic          line;
  logic          line_start;
  logic          draw_we;
  logic [AW-1:0] draw_addr;
  logic [7:0]    draw_data;
  logic          draw_done;
  logic          overrun;
  logic [7:0]    col_addr;

  // The video timing and the object drawer drive the buffer
  modport master (
    output pxl_cen, LHBL, draw_we, draw_addr, draw_data, draw_done,
    input  line, line_start, overrun, col_addr
  );

  // The line buffer itself
  modport slave (
    input  pxl_cen, LHBL, draw_we, draw_addr, draw_data, draw_done,
    output line, line_start, overrun, col_addr
  );

endinterface

// File: rtl/jtbubl_linebuf_ram.sv
// Single-clock dual-port RAM: port A is a write-only draw port, port B reads the
// old contents and may overwrite the same location on the same edge.
module jtbubl_linebuf_ram #(
  parameter int aw = 9,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [aw-1:0] addr_a,
  input  logic [dw-1:0] data_a,
  input  logic          we_b,
  input  logic [aw-1:0] addr_b,
  input  logic [dw-1:0] data_b,
  output logic [dw-1:0] q_b
);

  logic [dw-1:0] mem [0:(2**aw)-1];

  // Both ports share one process; port B returns the pre-write word
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    q_b <= mem[addr_b];
    if (we_b) mem[addr_b] <= data_b;
  end

endmodule

// File: rtl/jtbubl_linebuf.sv
// Double-buffered object line buffer: the drawer fills buffer[line] while
// buffer[~line] is scanned out at pixel rate and cleared behind the beam.
module jtbubl_linebuf
  import jtbubl_linebuf_pkg::*;
#(
  parameter int         AW     = 8,
  parameter logic [7:0] BLANK  = jtbubl_linebuf_pkg::BLANK,
  parameter logic [3:0] TRANSP = jtbubl_linebuf_pkg::TRANSP
) (
  input  logic             clk,
  input  logic             rst,
  jtbubl_linebuf_if.slave  bus
);

  logic          lhbl_l;
  logic          fall;
  logic          line_r;
  logic          line_start_r;
  logic          overrun_r;
  logic [7:0]    col_r;

  rd_state_t     st;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] rd_addr;
  logic          rd_buf;

  logic          we_a;
  logic [AW:0]   addr_a;
  logic          we_b;
  logic [AW:0]   addr_b;
  logic [7:0]    q_b;

  assign fall = lhbl_l & ~bus.LHBL;

  // Transparent draw pixels leave whatever an earlier object put there
  assign we_a   = bus.draw_we & (bus.draw_data[3:0] != TRANSP);
  assign addr_a = {line_r, bus.draw_addr};

  // While a READ is pending, port B stays on the latched pixel so a swap
  // on that edge cannot redirect the clear into the other buffer
  assign we_b   = (st == READ);
  assign addr_b = (st == READ) ? {rd_buf, rd_addr} : {~line_r, rd_cnt};

  assign bus.line       = line_r;
  assign bus.line_start = line_start_r;
  assign bus.overrun    = overrun_r;
  assign bus.col_addr   = col_r;

  jtbubl_linebuf_ram #(
    .aw (AW + 1),
    .dw (8)
  ) u_ram (
    .clk    (clk),
    .we_a   (we_a),
    .addr_a (addr_a),
    .data_a (bus.draw_data),
    .we_b   (we_b),
    .addr_b (addr_b),
    .data_b (BLANK),
    .q_b    (q_b)
  );

  // Swap buffers on each end of active video and flag a drawer that was late
  always_ff @(posedge clk) begin
    if (rst) begin
      lhbl_l       <= 1'b0;
      line_r       <= 1'b0;
      line_start_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      lhbl_l       <= bus.LHBL;
      line_start_r <= fall;
      if (fall) begin
        line_r <= ~line_r;
        if (!bus.draw_done) overrun_r <= 1'b1;
      end
    end
  end

  // Scan out one pixel per pxl_cen, clearing it right after it is read
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      rd_cnt  <= '0;
      rd_addr <= '0;
      rd_buf  <= 1'b0;
      col_r   <= BLANK;
    end else begin
      if (!bus.LHBL)        rd_cnt <= '0;
      else if (bus.pxl_cen) rd_cnt <= rd_cnt + 1'b1;

      case (st)
        IDLE: begin
          if (bus.pxl_cen && bus.LHBL) begin
            rd_addr <= rd_cnt;
            rd_buf  <= ~line_r;
            st      <= READ;
          end
        end
        READ: begin
          col_r <= q_b;
          st    <= IDLE;
        end
        default: st <= IDLE;
      endcase

      if (!bus.LHBL) col_r <= BLANK;
    end
  end

endmodule
